pwm_multich: RTL and testbench
==============================

PWM_MULTICH -- requirements
Module: pwm_multich

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent PWM outputs.
REQ-002 Parameter SAMPLE_W, default 4, per-channel sample width, two's complement.
REQ-003 Parameter CNT_W, default 5, period counter width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 globalreset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  run (1) / idle (0).
REQ-007 period  input  CNT_W  terminal count P; PWM frame length = P+1 cycles.
REQ-008 s_valid  input  1  sample word valid.
REQ-009 s_ready  output  1  holding buffer empty, can accept.
REQ-010 s_data  input  CHANNELS*SAMPLE_W  channel n in bits [n*SAMPLE_W +: SAMPLE_W], signed.
REQ-011 pwm_o  output  CHANNELS  registered PWM outputs.
REQ-012 frame_start  output  1  one-cycle pulse on the cycle the counter is 0 while enabled.
REQ-013 underrun  output  1  sticky: frame boundary reached with holding buffer empty.
REQ-014 clear_underrun  input  1  clears underrun.

Function
REQ-015 Counter cnt: 0..Pa, then wraps to 0; Pa = active period, loaded from period at each wrap and at reset exit.
REQ-016 Handshake: transfer when s_valid && s_ready; s_data is captured into the holding buffer; s_ready deasserts the next cycle.
REQ-017 s_ready = holding buffer empty; s_ready does not depend on s_valid combinationally.
REQ-018 At wrap (cnt == Pa, enable=1): if the holding buffer is full, copy it to the active duty registers and mark it empty (s_ready=1 next cycle).
REQ-019 At wrap with the holding buffer empty: keep the previous duties and set underrun.
REQ-020 Transfer on the wrap cycle while the holding buffer is empty: no bypass; underrun is set; the sample stays held for the following frame.
REQ-021 Duty conversion: d = sample + 2^(SAMPLE_W-1), with the MSB inverted to give offset binary in range 0..2^SAMPLE_W-1.
REQ-022 If d > Pa+1, clamp d to Pa+1 (output always high).
REQ-023 pwm_o[n] <= (d_n > cnt), registered, so output lags the counter by 1 cycle.
REQ-024 Width: compare uses max(SAMPLE_W, CNT_W)+1 bits, zero-extended, with no truncation.
REQ-025 d = 0 gives a constant-low output; d = Pa+1 gives a constant-high output.
REQ-026 enable=0: cnt held at 0; pwm_o=0; frame_start=0; no underrun set; handshake still accepted.
REQ-027 enable 0->1: the frame starts at cnt=0 with the current active duties.
REQ-028 A period change mid-frame takes effect only at the next wrap.
REQ-029 clear_underrun has priority over a simultaneous set; underrun reads 0 the next cycle.

Reset
REQ-030 While globalreset=1: cnt=0; pwm_o=0; frame_start=0; underrun=0; holding empty (s_ready=1).
REQ-031 Reset also sets active duties to midscale 2^(SAMPLE_W-1), clamped per REQ-022, and Pa=period.
REQ-032 Reset asserted mid-frame aborts the frame on the next edge; a pending held sample is discarded.

Verification (CHANNELS=2, SAMPLE_W=4, CNT_W=5, period=19, enable=1)
REQ-033 Reset release, no samples -> both outputs high 8 of 20 cycles; underrun=1 after the first wrap.
REQ-034 s_data ch0=0x7, ch1=0x8 accepted before a wrap -> next frame: ch0 high 15 cycles, ch1 low for all 20 cycles.
REQ-035 period=9 and sample 0x7 (d=15) -> clamped to 10; output high all 10 cycles; frame_start every 10 cycles.
REQ-036 Second s_valid while s_ready=0 -> not accepted; first sample applied at the wrap; s_ready=1 the cycle after the wrap.
REQ-037 Transfer exactly on the wrap cycle with the buffer empty -> underrun=1; sample applied one frame later.
REQ-038 globalreset pulsed at cnt=7 with a sample pending -> next cycle: cnt=0, pwm_o=0, s_ready=1; outputs return to midscale duty 8.

Source files
------------

// File: rtl/pwm_multich.sv
// ---------------------------------------------------------------------------
// pwm_multich
//   Multi-channel PWM generator fed by a single-entry sample holding buffer.
//   Each channel takes a signed sample, converts it to an offset-binary duty,
//   clamps it to the frame length and drives a registered PWM output.
//   New samples are swapped in only at the frame boundary (counter wrap).
//
// Ports
//   clk            : clock, all logic on the rising edge
//   globalreset    : synchronous active-high reset
//   enable         : 1 = run, 0 = idle (counter parked at 0, outputs low)
//   period         : terminal count P, frame length is P+1 cycles
//   s_valid        : sample word valid
//   s_ready        : holding buffer empty, a sample can be accepted
//   s_data         : CHANNELS signed samples, channel n at [n*SAMPLE_W +: SAMPLE_W]
//   pwm_o          : registered PWM outputs, one per channel
//   frame_start    : high while the counter is 0 and the generator is enabled
//   underrun       : sticky, a frame boundary was reached with no sample held
//   clear_underrun : clears underrun, wins over a simultaneous set
// ---------------------------------------------------------------------------
module pwm_multich #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 4,
  parameter int CNT_W    = 5
) (
  input  logic                         clk,
  input  logic                         globalreset,
  input  logic                         enable,
  input  logic [CNT_W-1:0]             period,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  output logic [CHANNELS-1:0]          pwm_o,
  output logic                         frame_start,
  output logic                         underrun,
  input  logic                         clear_underrun
);

  // Compare width holds both the largest duty and Pa+1 without truncation.
  localparam int CMP_W = ((SAMPLE_W > CNT_W) ? SAMPLE_W : CNT_W) + 1;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // Two's complement -> offset binary: adding 2^(SAMPLE_W-1) is an MSB flip.
  function automatic logic [SAMPLE_W-1:0] to_offset(input logic signed [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

  // Saturate the duty at Pa+1, which already means "high for the whole frame".
  function automatic logic [CMP_W-1:0] clamp_duty(input logic [SAMPLE_W-1:0] d,
                                                  input logic [CNT_W-1:0]    pa);
    logic [CMP_W-1:0] d_ext;
    logic [CMP_W-1:0] lim;
    d_ext = CMP_W'(d);
    lim   = CMP_W'(pa) + CMP_W'(1);
    return (d_ext > lim) ? lim : d_ext;
  endfunction

  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [CNT_W-1:0]                   pa_q, pa_d;
  logic [CHANNELS-1:0][CMP_W-1:0]     duty_q, duty_d, duty_rst;
  logic [CHANNELS*SAMPLE_W-1:0]       hold_q, hold_d;
  logic                               hold_full_q, hold_full_d;
  logic                               underrun_q, underrun_d;
  logic [CHANNELS-1:0]                pwm_q, pwm_d;
  logic                               wrap;
  logic                               xfer;
  logic                               underrun_set;

  always_comb begin
    wrap         = enable && (cnt_q == pa_q);
    xfer         = s_valid && !hold_full_q;
    underrun_set = 1'b0;
    cnt_d        = cnt_q;
    pa_d         = pa_q;
    duty_d       = duty_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    pwm_d        = '0;

    if (!enable) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // New duties are clamped against the period that becomes active with them.
    if (wrap) begin
      pa_d = period;
      if (hold_full_q) begin
        for (int n = 0; n < CHANNELS; n++) begin
          duty_d[n] = clamp_duty(to_offset($signed(hold_q[n*SAMPLE_W +: SAMPLE_W])), period);
        end
        hold_full_d = 1'b0;
      end else begin
        underrun_set = 1'b1;
      end
    end

    // A transfer on an empty-buffer wrap is held for the following frame, never bypassed.
    if (xfer) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    underrun_d = clear_underrun ? 1'b0 : (underrun_q | underrun_set);

    for (int n = 0; n < CHANNELS; n++) begin
      pwm_d[n]    = enable && (duty_q[n] > CMP_W'(cnt_q));
      duty_rst[n] = clamp_duty(MIDSCALE, period);
    end
  end

  always_ff @(posedge clk) begin
    if (globalreset) begin
      cnt_q       <= '0;
      pa_q        <= period;
      duty_q      <= duty_rst;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      pwm_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pa_q        <= pa_d;
      duty_q      <= duty_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      pwm_q       <= pwm_d;
    end
  end

  // Sample payload needs no reset: it is only consumed when hold_full_q is set.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign s_ready     = !hold_full_q;
  assign pwm_o       = pwm_q;
  assign underrun    = underrun_q;
  assign frame_start = enable && !globalreset && (cnt_q == '0);

endmodule

// File: tb/tb_pwm_multich.sv
module tb_pwm_multich;

  logic       clk = 1'b0;
  logic       globalreset;
  logic       enable;
  logic [4:0] period;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [1:0] pwm_o;
  logic       frame_start;
  logic       underrun;
  logic       clear_underrun;

  int checks = 0;
  int errors = 0;

  pwm_multich #(.CHANNELS(2), .SAMPLE_W(4), .CNT_W(5)) dut (
    .clk           (clk),
    .globalreset   (globalreset),
    .enable        (enable),
    .period        (period),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .pwm_o         (pwm_o),
    .frame_start   (frame_start),
    .underrun      (underrun),
    .clear_underrun(clear_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Counts high cycles over one frame, starting at a negedge where cnt==0.
  task automatic count_frame(input int p, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i <= p; i++) begin
      @(negedge clk);
      c0 += int'(pwm_o[0]);
      c1 += int'(pwm_o[1]);
    end
  endtask

  task automatic test_reset;
    globalreset = 1'b1; enable = 1'b1; period = 5'd19;
    s_valid = 1'b0; s_data = '0; clear_underrun = 1'b0;
    step(3);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    checks++; if (pwm_o !== 2'b00) begin errors++; $display("FAIL reset_pwm: got %b want 00", pwm_o); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_midscale;
    int c0, c1;
    bit seen;
    globalreset = 1'b0;
    #1;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL exit_frame_start: got %b want 1", frame_start); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL exit_underrun: got %b want 0", underrun); end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_wait_frame: got no frame_start want pulse"); end
    count_frame(19, c0, c1);
    checks++; if (c0 != 8 || c1 != 8) begin errors++; $display("FAIL mid_duty: got %0d/%0d want 8/8", c0, c1); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL mid_underrun: got %b want 1", underrun); end
  endtask

  task automatic test_clear_underrun;
    step(19);
    clear_underrun = 1'b1;
    step(1);
    clear_underrun = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clear_priority: got %b want 0", underrun); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL clear_frame_start: got %b want 1", frame_start); end
  endtask

  task automatic test_sample;
    int c0, c1;
    bit seen;
    step(3);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL smp_ready_before: got %b want 1", s_ready); end
    s_valid = 1'b1; s_data = 8'h87;
    step(1);
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL smp_ready_after: got %b want 0", s_ready); end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL smp_wait_frame: got no frame_start want pulse"); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL smp_ready_wrap: got %b want 1", s_ready); end
    count_frame(19, c0, c1);
    checks++; if (c0 != 15 || c1 != 0) begin errors++; $display("FAIL smp_duty: got %0d/%0d want 15/0", c0, c1); end
  endtask

  task automatic test_back_to_back;
    int c0, c1;
    step(2);
    s_valid = 1'b1; s_data = 8'h20;
    step(1);
    s_data = 8'h4C;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low%0d: got %b want 0", i, s_ready); end
    end
    s_valid = 1'b0;
    step(11);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_prewrap: got %b want 0", s_ready); end
    step(1);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_postwrap: got %b want 1", s_ready); end
    count_frame(19, c0, c1);
    checks++; if (c0 != 8 || c1 != 10) begin errors++; $display("FAIL b2b_duty: got %0d/%0d want 8/10", c0, c1); end
  endtask

  task automatic test_wrap_transfer;
    int c0, c1;
    clear_underrun = 1'b1;
    step(1);
    clear_underrun = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL wt_cleared: got %b want 0", underrun); end
    step(18);
    s_valid = 1'b1; s_data = 8'hF7;
    step(1);
    s_valid = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL wt_underrun: got %b want 1", underrun); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL wt_held: got %b want 0", s_ready); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL wt_frame_start: got %b want 1", frame_start); end
    count_frame(19, c0, c1);
    checks++; if (c0 != 8 || c1 != 10) begin errors++; $display("FAIL wt_old_duty: got %0d/%0d want 8/10", c0, c1); end
    count_frame(19, c0, c1);
    checks++; if (c0 != 15 || c1 != 7) begin errors++; $display("FAIL wt_new_duty: got %0d/%0d want 15/7", c0, c1); end
  endtask

  task automatic test_period_clamp;
    int c0, c1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL pc_ready: got %b want 1", s_ready); end
    period = 5'd9;
    s_valid = 1'b1; s_data = 8'h77;
    step(1);
    s_valid = 1'b0;
    step(18);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL pc_old_len: got %b want 0", frame_start); end
    step(1);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL pc_old_wrap: got %b want 1", frame_start); end
    count_frame(9, c0, c1);
    checks++; if (c0 != 10 || c1 != 10) begin errors++; $display("FAIL pc_clamp: got %0d/%0d want 10/10", c0, c1); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL pc_new_wrap: got %b want 1", frame_start); end
    step(9);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL pc_mid: got %b want 0", frame_start); end
    step(1);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL pc_period10: got %b want 1", frame_start); end
  endtask

  task automatic test_enable;
    int c0, c1;
    bit bad;
    enable = 1'b0; clear_underrun = 1'b1;
    step(1);
    clear_underrun = 1'b0;
    checks++; if (pwm_o !== 2'b00) begin errors++; $display("FAIL en_pwm: got %b want 00", pwm_o); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL en_frame_start: got %b want 0", frame_start); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL en_ready: got %b want 1", s_ready); end
    s_valid = 1'b1; s_data = 8'h88;
    step(1);
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL en_accept: got %b want 0", s_ready); end
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (pwm_o !== 2'b00 || frame_start !== 1'b0 || underrun !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL en_idle: got activity while idle want none"); end
    enable = 1'b1;
    #1;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL en_start: got %b want 1", frame_start); end
    count_frame(9, c0, c1);
    checks++; if (c0 != 10 || c1 != 10) begin errors++; $display("FAIL en_first_frame: got %0d/%0d want 10/10", c0, c1); end
    count_frame(9, c0, c1);
    checks++; if (c0 != 0 || c1 != 0) begin errors++; $display("FAIL en_zero_duty: got %0d/%0d want 0/0", c0, c1); end
  endtask

  task automatic test_reset_mid;
    int c0, c1;
    period = 5'd19;
    s_valid = 1'b1; s_data = 8'h77;
    step(1);
    s_valid = 1'b0;
    step(6);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rm_pending: got %b want 0", s_ready); end
    globalreset = 1'b1;
    step(1);
    checks++; if (pwm_o !== 2'b00) begin errors++; $display("FAIL rm_pwm: got %b want 00", pwm_o); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", s_ready); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rm_underrun: got %b want 0", underrun); end
    globalreset = 1'b0;
    #1;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rm_start: got %b want 1", frame_start); end
    count_frame(19, c0, c1);
    checks++; if (c0 != 8 || c1 != 8) begin errors++; $display("FAIL rm_mid1: got %0d/%0d want 8/8", c0, c1); end
    count_frame(19, c0, c1);
    checks++; if (c0 != 8 || c1 != 8) begin errors++; $display("FAIL rm_discard: got %0d/%0d want 8/8", c0, c1); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL rm_underrun_after: got %b want 1", underrun); end
  endtask

  initial begin
    test_reset();
    test_midscale();
    test_clear_underrun();
    test_sample();
    test_back_to_back();
    test_wrap_transfer();
    test_period_clamp();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
